// File: rtl/msg_fifo_stream_reg_pkg.sv
// Shared defaults for the message FIFO and stream skid register.
// Holds payload widths and FIFO depth constants.
package msg_fifo_stream_reg_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 26;
    localparam int unsigned DEF_MSG_WIDTH  = 32;
    localparam int unsigned DEF_MSG_DEPTH  = 256;
    localparam int unsigned DEF_MSG_AW     = $clog2(DEF_MSG_DEPTH);

endpackage

// File: rtl/msg_fifo_stream_reg_stream_reg.sv
// Two-entry valid/ready skid buffer with a registered ready_o.
// Main register feeds the output; skid catches the beat in flight.
module stream_reg
    import msg_fifo_stream_reg_pkg::*;
#(
    parameter int unsigned W = DEF_DATA_WIDTH
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    input  logic         ready_i
);

    logic         main_v_q, main_v_d;
    logic         skid_v_q, skid_v_d;
    logic         ready_q, ready_d;
    logic [W-1:0] main_data_q, main_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         accept;
    logic         drain;

    assign accept = valid_i & ready_q;
    assign drain  = ~main_v_q | ready_i;

    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (drain) begin
            if (skid_v_q) begin
                main_v_d    = 1'b1;
                main_data_d = skid_data_q;
                skid_v_d    = 1'b0;
            end else begin
                main_v_d = accept;
                if (accept) main_data_d = data_i;
            end
        end else if (accept) begin
            skid_v_d    = 1'b1;
            skid_data_d = data_i;
        end
        // ready only depends on local occupancy, never on ready_i
        ready_d = ~skid_v_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk_i) begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
    end

    assign ready_o = ready_q;
    assign valid_o = main_v_q;
    assign data_o  = main_data_q;

endmodule

// File: rtl/msg_fifo_stream_reg.sv
// Stream skid register alongside a show-ahead message FIFO.
// FIFO pointers carry one extra wrap bit to tell full from empty.
module msg_fifo_stream_reg
    import msg_fifo_stream_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MSG_WIDTH  = DEF_MSG_WIDTH,
    parameter int unsigned MSG_DEPTH  = DEF_MSG_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         valid_in,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic                         ready_out,
    output logic                         valid_out,
    output logic [DATA_WIDTH-1:0]        data_out,
    input  logic                         ready_in,
    input  logic                         sclr,
    input  logic                         wrreq,
    input  logic [MSG_WIDTH-1:0]         data,
    input  logic                         rdreq,
    output logic [MSG_WIDTH-1:0]         q,
    output logic [$clog2(MSG_DEPTH)-1:0] usedw,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned AW = $clog2(MSG_DEPTH);

    stream_reg #(
        .W (DATA_WIDTH)
    ) u_stream_reg (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .valid_i (valid_in),
        .data_i  (data_in),
        .ready_o (ready_out),
        .valid_o (valid_out),
        .data_o  (data_out),
        .ready_i (ready_in)
    );

    logic [MSG_WIDTH-1:0] mem [MSG_DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count;
    logic                 do_wr;
    logic                 do_rd;

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = count[AW];
    assign usedw = count[AW-1:0];
    assign q     = mem[rd_ptr_q[AW-1:0]];

    // a pop frees the slot, so a write while full is fine alongside rdreq
    assign do_rd = rdreq & ~empty;
    assign do_wr = wrreq & (~full | rdreq);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (sclr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !sclr) mem[wr_ptr_q[AW-1:0]] <= data;
    end

endmodule

// File: tb/tb_msg_fifo_stream_reg.sv
// Directed bench for the stream skid register and message FIFO.
module tb_msg_fifo_stream_reg;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        valid_in;
    logic [25:0] data_in;
    logic        ready_out;
    logic        valid_out;
    logic [25:0] data_out;
    logic        ready_in;
    logic        sclr;
    logic        wrreq;
    logic [31:0] data;
    logic        rdreq;
    logic [31:0] q;
    logic [7:0]  usedw;
    logic        empty;
    logic        full;

    int errors = 0;
    int checks = 0;

    msg_fifo_stream_reg dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_in  (ready_in),
        .sclr      (sclr),
        .wrreq     (wrreq),
        .data      (data),
        .rdreq     (rdreq),
        .q         (q),
        .usedw     (usedw),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        ready_in = 1'b0;
        sclr     = 1'b0;
        wrreq    = 1'b0;
        data     = '0;
        rdreq    = 1'b0;
        step();
        step();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid_out got=%b exp=0", valid_out);
        end
        checks++;
        if (ready_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready_out got=%b exp=0", ready_out);
        end
        checks++;
        if (usedw !== 8'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL rst_fifo got usedw=%0d empty=%b full=%b exp 0/1/0",
                     usedw, empty, full);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (ready_out !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready_rise got=%b exp=1", ready_out);
        end
    endtask

    task automatic test_throughput();
        ready_in = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            valid_in = 1'b1;
            data_in  = 26'(i);
            step();
            checks++;
            if (valid_out !== 1'b1 || data_out !== 26'(i) || ready_out !== 1'b1) begin
                errors++;
                $display("FAIL thru_beat%0d got v=%b d=%h r=%b exp v=1 d=%h r=1",
                         i, valid_out, data_out, ready_out, 26'(i));
            end
        end
        valid_in = 1'b0;
        step();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL thru_idle got=%b exp=0", valid_out);
        end
    endtask

    task automatic test_backpressure();
        ready_in = 1'b0;
        valid_in = 1'b1;
        data_in  = 26'h11;
        step();
        checks++;
        if (valid_out !== 1'b1 || data_out !== 26'h11 || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_first got v=%b d=%h r=%b exp 1/11/1",
                     valid_out, data_out, ready_out);
        end
        data_in = 26'h12;
        step();
        checks++;
        if (ready_out !== 1'b0 || data_out !== 26'h11) begin
            errors++;
            $display("FAIL bp_skid got r=%b d=%h exp r=0 d=11", ready_out, data_out);
        end
        data_in = 26'h13;
        step();
        checks++;
        if (ready_out !== 1'b0 || data_out !== 26'h11 || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got r=%b v=%b d=%h exp r=0 v=1 d=11",
                     ready_out, valid_out, data_out);
        end
        ready_in = 1'b1;
        step();
        checks++;
        if (data_out !== 26'h12 || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got d=%h r=%b exp d=12 r=1", data_out, ready_out);
        end
        step();
        checks++;
        if (data_out !== 26'h13 || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL bp_third got v=%b d=%h exp v=1 d=13", valid_out, data_out);
        end
        valid_in = 1'b0;
        step();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got=%b exp=0", valid_out);
        end
    endtask

    task automatic test_show_ahead();
        logic [31:0] words [3];
        words[0] = 32'h00524242;
        words[1] = 32'h00640032;
        words[2] = 32'h01E000F0;
        for (int i = 0; i < 3; i++) begin
            wrreq = 1'b1;
            data  = words[i];
            step();
        end
        wrreq = 1'b0;
        checks++;
        if (q !== words[0] || usedw !== 8'd3 || empty !== 1'b0) begin
            errors++;
            $display("FAIL sa_fill got q=%h usedw=%0d empty=%b exp q=%h 3 0",
                     q, usedw, empty, words[0]);
        end
        for (int i = 1; i <= 3; i++) begin
            rdreq = 1'b1;
            step();
            rdreq = 1'b0;
            checks++;
            if (usedw !== 8'(3 - i) || (i < 3 && q !== words[i])) begin
                errors++;
                $display("FAIL sa_pop%0d got q=%h usedw=%0d exp usedw=%0d",
                         i, q, usedw, 3 - i);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL sa_empty got=%b exp=1", empty);
        end
        rdreq = 1'b1;
        step();
        checks++;
        if (usedw !== 8'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL sa_underflow got usedw=%0d empty=%b exp 0/1", usedw, empty);
        end
        wrreq = 1'b1;
        data  = 32'hCAFE0001;
        step();
        rdreq = 1'b0;
        wrreq = 1'b0;
        checks++;
        if (usedw !== 8'd1 || empty !== 1'b0 || q !== 32'hCAFE0001) begin
            errors++;
            $display("FAIL sa_rw_empty got usedw=%0d empty=%b q=%h exp 1/0/cafe0001",
                     usedw, empty, q);
        end
        rdreq = 1'b1;
        step();
        rdreq = 1'b0;
    endtask

    task automatic test_full();
        for (int i = 0; i < 256; i++) begin
            wrreq = 1'b1;
            data  = 32'(i);
            step();
        end
        checks++;
        if (full !== 1'b1 || usedw !== 8'd0 || empty !== 1'b0 || q !== 32'd0) begin
            errors++;
            $display("FAIL full_fill got full=%b usedw=%0d empty=%b q=%h exp 1/0/0/0",
                     full, usedw, empty, q);
        end
        data = 32'hDEAD;
        step();
        checks++;
        if (full !== 1'b1 || usedw !== 8'd0 || q !== 32'd0) begin
            errors++;
            $display("FAIL full_overflow got full=%b usedw=%0d q=%h exp 1/0/0",
                     full, usedw, q);
        end
        rdreq = 1'b1;
        data  = 32'hBEEF;
        step();
        wrreq = 1'b0;
        checks++;
        if (full !== 1'b1 || usedw !== 8'd0 || q !== 32'd1) begin
            errors++;
            $display("FAIL full_rw got full=%b usedw=%0d q=%h exp 1/0/1", full, usedw, q);
        end
        for (int i = 0; i < 255; i++) begin
            step();
            checks++;
            if ((i < 254 && q !== 32'(i + 2)) || (i == 254 && q !== 32'hBEEF)) begin
                errors++;
                $display("FAIL full_drain%0d got q=%h", i, q);
            end
        end
        checks++;
        if (usedw !== 8'd1 || full !== 1'b0) begin
            errors++;
            $display("FAIL full_last got usedw=%0d full=%b exp 1/0", usedw, full);
        end
        step();
        rdreq = 1'b0;
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL full_empty got=%b exp=1", empty);
        end
    endtask

    task automatic test_sclr();
        for (int i = 0; i < 5; i++) begin
            wrreq = 1'b1;
            data  = 32'(100 + i);
            step();
        end
        checks++;
        if (usedw !== 8'd5) begin
            errors++;
            $display("FAIL sclr_fill got usedw=%0d exp 5", usedw);
        end
        sclr = 1'b1;
        step();
        sclr  = 1'b0;
        wrreq = 1'b0;
        checks++;
        if (usedw !== 8'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL sclr_clear got usedw=%0d empty=%b full=%b exp 0/1/0",
                     usedw, empty, full);
        end
    endtask

    task automatic test_async_reset();
        ready_in = 1'b0;
        valid_in = 1'b1;
        data_in  = 26'h2A;
        wrreq    = 1'b1;
        data     = 32'h55;
        step();
        data_in = 26'h2B;
        step();
        valid_in = 1'b0;
        wrreq    = 1'b0;
        checks++;
        if (valid_out !== 1'b1 || usedw !== 8'd2) begin
            errors++;
            $display("FAIL ar_pre got v=%b usedw=%0d exp 1/2", valid_out, usedw);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (valid_out !== 1'b0 || empty !== 1'b1 || usedw !== 8'd0 || ready_out !== 1'b0) begin
            errors++;
            $display("FAIL ar_async got v=%b empty=%b usedw=%0d r=%b exp 0/1/0/0",
                     valid_out, empty, usedw, ready_out);
        end
        step();
        reset_n  = 1'b1;
        ready_in = 1'b1;
        step();
        checks++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL ar_after got r=%b v=%b empty=%b exp 1/0/1",
                     ready_out, valid_out, empty);
        end
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_backpressure();
        test_show_ahead();
        test_full();
        test_sclr();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msg_fifo_stream_reg.md
MSG_FIFO_STREAM_REG -- requirements
Module: msg_fifo_stream_reg

Interface
REQ-001 Parameter DATA_WIDTH, default 26: width of the stream register payload.
REQ-002 Parameter MSG_WIDTH, default 32: width of a FIFO word.
REQ-003 Parameter MSG_DEPTH, default 256: FIFO capacity in words; must be a power of 2.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 valid_in  in  1  upstream stream beat valid.
REQ-008 data_in  in  DATA_WIDTH  upstream payload, e.g. {rgb, sop, eop}.
REQ-009 ready_out  out  1  stream register can accept a beat.
REQ-010 valid_out  out  1  downstream beat valid.
REQ-011 data_out  out  DATA_WIDTH  downstream payload.
REQ-012 ready_in  in  1  downstream accepts a beat.
REQ-013 sclr  in  1  synchronous FIFO clear.
REQ-014 wrreq  in  1  FIFO write request.
REQ-015 data  in  MSG_WIDTH  FIFO write word.
REQ-016 rdreq  in  1  FIFO read-acknowledge; pops the head word.
REQ-017 q  out  MSG_WIDTH  FIFO head word (show-ahead).
REQ-018 usedw  out  log2(MSG_DEPTH)  occupancy modulo MSG_DEPTH.
REQ-019 empty  out  1  FIFO holds no words.
REQ-020 full  out  1  FIFO holds MSG_DEPTH words.

Function
REQ-021 The stream path SHALL accept a beat on any edge where valid_in & ready_out, and SHALL deliver it on any edge where valid_out & ready_in.
REQ-022 The stream path SHALL be a 2-entry skid buffer with one main register and one skid register.
REQ-023 Stream latency SHALL be exactly 1 cycle.
REQ-024 The stream path SHALL sustain 1 beat/cycle when ready_in is held high.
REQ-025 ready_out SHALL be registered and SHALL not depend combinationally on ready_in.
REQ-026 A beat accepted while the main register is stalled SHALL go to the skid register, and ready_out SHALL fall on the next edge.
REQ-027 When the main register drains, the skid entry SHALL move into it and ready_out SHALL rise again.
REQ-028 Beat order SHALL be preserved, with no loss or duplication.
REQ-029 data_out SHALL hold stable while valid_out & ~ready_in.
REQ-030 The FIFO write SHALL be accepted when wrreq & (~full | rdreq).
REQ-031 The FIFO read SHALL be accepted when rdreq & ~empty.
REQ-032 A wrreq while full without rdreq SHALL be ignored.
REQ-033 A rdreq while empty SHALL be ignored.
REQ-034 On simultaneous rdreq and wrreq with the FIFO empty, only the write SHALL take effect.
REQ-035 q SHALL present the oldest word combinationally from the stored state whenever ~empty.
REQ-036 After a pop, q SHALL show the next word in the following cycle.
REQ-037 q SHALL be don't-care when empty.
REQ-038 usedw, empty and full SHALL update on the edge of the accepted operation.
REQ-039 On a simultaneous accepted read and write, the count SHALL be unchanged.
REQ-040 usedw SHALL wrap to 0 at MSG_DEPTH words, with full=1 and empty=0 at that point.
REQ-041 sclr SHALL take priority over wrreq and rdreq.
REQ-042 sclr SHALL empty the FIFO on the next edge: usedw=0, empty=1, full=0.

Reset
REQ-043 While reset_n=0, the outputs SHALL be: valid_out=0, ready_out=0, usedw=0, empty=1, full=0.
REQ-044 While reset_n=0, the FIFO read/write pointers and the skid-register valid SHALL be cleared.
REQ-045 ready_out SHALL rise on the first clk edge after reset_n deasserts.
REQ-046 Payload storage SHALL not be reset.
REQ-047 Reset mid-transfer SHALL discard all in-flight beats and FIFO words.

Structure
REQ-048 A shared package SHALL hold the default widths (26, 32), MSG_DEPTH=256 and its log2.
REQ-049 The stream skid buffer SHALL be a sub-module named stream_reg, instanced once.
REQ-050 The FIFO SHALL be inline RAM plus pointers with one extra wrap bit for full/empty.

Verification
REQ-051 Stream throughput: ready_in=1, 10 back-to-back beats 0x0000001..0x000000A -> same order on data_out 1 cycle later, ready_out constantly 1.
REQ-052 Stream backpressure: ready_in=0 for 3 cycles during a burst -> ready_out falls after the 2nd accepted beat, no beat lost, data_out stable, order intact after release.
REQ-053 FIFO show-ahead: write "RBB"=0x00524242, 0x00640032, 0x01E000F0 -> q=0x00524242 and usedw=3; each rdreq pops -> q advances; empty=1 after the 3rd pop.
REQ-054 FIFO full: 256 writes -> full=1, usedw=0; a 257th write is ignored; rdreq+wrreq together -> count stays 256 and the new word lands last.
REQ-055 sclr with wrreq asserted in the same cycle on a FIFO holding 5 words -> usedw=0, empty=1.
REQ-056 Async reset mid-burst -> valid_out=0 and empty=1 immediately, with no clock edge.
